// File: rtl/gpu_pkg.sv
// Shared GPU constants: instruction word width, field offsets and the packed
// instruction type used between the host write path and decode_block.
package gpu_pkg;

  localparam int unsigned INST_W = 82;

  // Instruction field offsets (LSB positions; multi-bit fields give MSB too).
  localparam int unsigned INST_TYPE_BIT = 0;
  localparam int unsigned VERT_NUM_BIT  = 1;
  localparam int unsigned V0_LSB        = 2;
  localparam int unsigned V0_MSB        = 17;
  localparam int unsigned V1_LSB        = 18;
  localparam int unsigned V1_MSB        = 33;
  localparam int unsigned V2_LSB        = 34;
  localparam int unsigned V2_MSB        = 49;
  localparam int unsigned LAYER_BIT     = 50;
  localparam int unsigned FILL_BIT      = 51;
  localparam int unsigned COLOR_LSB     = 52;
  localparam int unsigned COLOR_MSB     = 75;
  localparam int unsigned TEX_LSB       = 76;
  localparam int unsigned TEX_MSB       = 77;
  localparam int unsigned ALPHA_LSB     = 78;
  localparam int unsigned ALPHA_MSB     = 81;

  typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Modulo-DEPTH pointer with enable. Wraps DEPTH-1 -> 0 by explicit compare so
// non-power-of-two depths work.
// Ports:
//   clk   - rising-edge clock
//   n_rst - synchronous active-low reset (ptr -> 0)
//   clear - synchronous flush (ptr -> 0), lower priority than n_rst
//   en    - advance pointer this cycle
//   ptr   - current pointer value, 0..DEPTH-1
module fifo_wrap_ctr #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          en,
  output logic [PW-1:0] ptr
);
  import gpu_pkg::*;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/inst_fifo.sv
// Instruction buffer between the host write interface and decode_block.
// First-word-fall-through: the oldest word is always presented on rdata.
// Ports:
//   clk, n_rst       - clock, synchronous active-low reset
//   clear            - synchronous flush of contents and sticky flags
//   push, wdata      - write request and instruction word
//   pop              - discard current head word
//   rdata            - head word, '0 when empty (null instruction)
//   empty, full      - occupancy status
//   count            - number of words held
//   overflow         - sticky: push while full without a simultaneous pop
//   underflow        - sticky: pop while empty
module inst_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = INST_W,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign wr_en   = do_push && n_rst && !clear;

  assign rdata = empty ? '0 : mem[rd_ptr];

  fifo_wrap_ctr #(
    .DEPTH (DEPTH)
  ) u_rd_ctr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .en    (do_pop),
    .ptr   (rd_ptr)
  );

  fifo_wrap_ctr #(
    .DEPTH (DEPTH)
  ) u_wr_ctr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .en    (do_push),
    .ptr   (wr_ptr)
  );

  // Storage carries no reset; validity is tracked solely by count/pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 82;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             n_rst;
  logic             clear;
  logic             push;
  logic [WIDTH-1:0] wdata;
  logic             pop;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .push      (push),
    .wdata     (wdata),
    .pop       (pop),
    .rdata     (rdata),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents as a plain queue plus sticky flags.
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  // Scoreboard: words expected to be consumed by each accepted pop.
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, then check status after the edge.
  task automatic step(input logic p, input logic po, input logic [WIDTH-1:0] d,
                      input logic c = 1'b0, input logic r = 1'b1);
    logic [WIDTH-1:0] exp_rd;
    n_rst = r;
    clear = c;
    push  = p;
    pop   = po;
    wdata = d;
    if (!r || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      int sz = mq.size();
      if (po && sz == 0) m_unf = 1'b1;
      if (p && sz == DEPTH && !po) m_ovf = 1'b1;
      if (po && sz > 0) exp_q.push_back(mq.pop_front());
      if (p && (sz < DEPTH || po)) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    exp_rd = (mq.size() > 0) ? mq[0] : '0;
    check("count", WIDTH'(count), WIDTH'(mq.size()));
    check("empty", WIDTH'(empty), WIDTH'(mq.size() == 0));
    check("full", WIDTH'(full), WIDTH'(mq.size() == DEPTH));
    check("overflow", WIDTH'(overflow), WIDTH'(m_ovf));
    check("underflow", WIDTH'(underflow), WIDTH'(m_unf));
    check("rdata", rdata, exp_rd);
  endtask

  // Monitor: whenever the DUT is about to consume its head, compare it.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && clear === 1'b0 && pop === 1'b1 && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", rdata, '1);
      end else begin
        check("pop_data", rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] w;
    n_rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;

    // Reset then idle.
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0);

    // Two pushes then two pops.
    step(1'b1, 1'b0, 82'h1);
    step(1'b1, 1'b0, 82'h2_0000_0003);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);

    // Fill, then overflow attempt with 0xABC.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(100 + i));
    step(1'b1, 1'b0, 82'hABC);

    // Full with push+pop: 0x55 accepted, no overflow change beyond sticky.
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(200 + i));
    step(1'b1, 1'b1, 82'h55);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

    // Underflow, then push+pop on empty.
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 82'h7);
    step(1'b0, 1'b1, '0);

    // Wrap with occupancy 1..3, then clear at count 3.
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, WIDTH'(300 + i));
    for (int i = 3; i < 20; i++) step(1'b1, 1'b1, WIDTH'(300 + i));
    step(1'b0, 1'b0, '0, 1'b1);

    // Same with reset mid-stream.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, WIDTH'(400 + i));
    for (int i = 3; i < 11; i++) step(1'b1, 1'b1, WIDTH'(400 + i));
    step(1'b1, 1'b1, 82'hDEAD, 1'b0, 1'b0);

    // Randomized traffic with occasional clear/reset.
    for (int i = 0; i < 400; i++) begin
      w = {$urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), w,
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 79) != 0));
    end

    step(1'b0, 1'b0, '0);
    check("scoreboard_drained", WIDTH'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
